// File: rtl/clock_mode_controller.sv
// Control and sequencing for the digital clock: button conditioning
// (sync, debounce, edge detect), the RUN/SET_SEC/SET_MIN/SET_HR mode FSM,
// the 1 Hz prescaler and the registered increment strobes for the counters.
module clock_mode_controller #(
    parameter int TICK_DIV        = 32768,
    parameter int DEBOUNCE_CYCLES = 655
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [1:0] mode,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hr_inc,
    output logic       carry_en,
    output logic       mode_led
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_SEC = 2'd1,
        SET_MIN = 2'd2,
        SET_HR  = 2'd3
    } mode_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    // Bit 0 of each button vector is the mode button, bit 1 the increment button.
    localparam int MODE_B = 0;
    localparam int INC_B  = 1;

    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_prev;
    logic [1:0]    press;
    logic [DW-1:0] deb_cnt [2];

    assign btn_raw = {inc_btn, mode_btn};

    // Synchronise, debounce and rising-edge detect both buttons identically.
    always_ff @(posedge clock) begin
        // NOTE: all sequential state uses non-blocking assignment so every
        // register samples the pre-edge value of its neighbours.
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            press    <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            deb_prev <= deb;
            press    <= deb & ~deb_prev;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    mode_e         state_q;
    mode_e         state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          sec_d;
    logic          min_d;
    logic          hr_d;
    logic          mode_press;
    logic          inc_press;
    logic          run_active;

    assign mode_press = press[MODE_B];
    assign inc_press  = press[INC_B];

    // The prescaler only runs while RUN persists through this edge; leaving
    // RUN discards any partial count so re-entry always starts from zero.
    assign run_active = (state_q == RUN) && !mode_press;

    // Next mode, prescaler step and increment strobe selection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        presc_d = '0;
        sec_d   = 1'b0;
        min_d   = 1'b0;
        hr_d    = 1'b0;

        if (mode_press) begin
            state_d = mode_e'(state_q + 2'd1);
        end

        if (run_active) begin
            if (presc_q == PRESC_LAST) begin
                sec_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // Field strobes follow the pre-advance mode, even when a mode press
        // lands in the same cycle.
        if (inc_press) begin
            case (state_q)
                SET_SEC: sec_d = 1'b1;
                SET_MIN: min_d = 1'b1;
                SET_HR:  hr_d  = 1'b1;
                default: ;
            endcase
        end
    end

    // Mode register, prescaler and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= RUN;
            presc_q  <= '0;
            sec_inc  <= 1'b0;
            min_inc  <= 1'b0;
            hr_inc   <= 1'b0;
            carry_en <= 1'b1;
            mode_led <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            sec_inc  <= sec_d;
            min_inc  <= min_d;
            hr_inc   <= hr_d;
            carry_en <= (state_d == RUN);
            mode_led <= (state_d != RUN);
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Self-checking bench for clock_mode_controller: directed scenarios followed
// by random button activity, scored against an event-level reference model.
module tb_clock_mode_controller;

    localparam int TICK = 10;
    localparam int DEB  = 4;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn  = 1'b0;
    logic [1:0] mode;
    logic       sec_inc;
    logic       min_inc;
    logic       hr_inc;
    logic       carry_en;
    logic       mode_led;

    int tests = 0;
    int fails = 0;

    clock_mode_controller #(
        .TICK_DIV        (TICK),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .mode     (mode),
        .sec_inc  (sec_inc),
        .min_inc  (min_inc),
        .hr_inc   (hr_inc),
        .carry_en (carry_en),
        .mode_led (mode_led)
    );

    always #5 clock = ~clock;

    // Expected visible event: a strobe and/or a mode change at a given edge.
    typedef struct {
        int cyc;
        int mode;
        int strobes;   // {sec, min, hr}
    } ev_t;

    // Accepted button press whose effect lands at edge 'due'.
    typedef struct {
        int due;
        int btn;
    } pend_t;

    ev_t   exp_q[$];
    pend_t pend_q[$];

    int cyc       = 0;
    bit started   = 1'b0;
    int mode_m    = 0;
    int run_start = 0;
    int deb_m [2] = '{0, 0};
    int run_m [2] = '{0, 0};

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a press is accepted once the raw button has differed
    // from its accepted level for DEB consecutive samples; its effect reaches
    // the outputs four edges later. Seconds ticks fall every TICK edges after
    // RUN was entered while RUN persists.
    always @(posedge clock) begin : model
        bit    mp;
        bit    ip;
        int    v;
        int    nm;
        int    strb;
        pend_t pe;
        ev_t   ev;
        cyc++;
        if (!reset_n) begin
            if (started && mode_m != 0) begin
                ev.cyc = cyc; ev.mode = 0; ev.strobes = 0;
                exp_q.push_back(ev);
            end
            started   = 1'b1;
            mode_m    = 0;
            run_start = cyc;
            deb_m     = '{0, 0};
            run_m     = '{0, 0};
            pend_q.delete();
        end else if (started) begin
            mp = 1'b0;
            ip = 1'b0;
            while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                if (pend_q[0].btn == 0) mp = 1'b1;
                else                    ip = 1'b1;
                void'(pend_q.pop_front());
            end

            for (int b = 0; b < 2; b++) begin
                v = (b == 0) ? int'(mode_btn) : int'(inc_btn);
                if (v != deb_m[b]) begin
                    run_m[b]++;
                    if (run_m[b] == DEB) begin
                        deb_m[b] = v;
                        run_m[b] = 0;
                        if (v == 1) begin
                            pe.due = cyc + 4;
                            pe.btn = b;
                            pend_q.push_back(pe);
                        end
                    end
                end else begin
                    run_m[b] = 0;
                end
            end

            nm   = mp ? (mode_m + 1) % 4 : mode_m;
            strb = 0;
            if (mode_m == 0) begin
                if (!mp && cyc > run_start && (cyc - run_start) % TICK == 0) strb = 4;
            end else if (ip) begin
                strb = 1 << (3 - mode_m);
            end
            if (nm == 0 && mode_m != 0) run_start = cyc;
            if (strb != 0 || nm != mode_m) begin
                ev.cyc = cyc; ev.mode = nm; ev.strobes = strb;
                exp_q.push_back(ev);
            end
            mode_m = nm;
        end
    end

    // Monitor: on the falling edge, match every visible DUT event against
    // the oldest expected event.
    logic [1:0] prev_mode = 2'd0;
    always @(negedge clock) begin : monitor
        ev_t e;
        if (started) begin
            check("carry_en_decode", int'(carry_en), int'(mode == 2'd0));
            check("mode_led_decode", int'(mode_led), int'(mode != 2'd0));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_event: expected mode %0d strobes %0d at cycle %0d, nothing seen",
                         exp_q[0].mode, exp_q[0].strobes, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (sec_inc || min_inc || hr_inc || mode != prev_mode) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got mode %0d strobes %0d at cycle %0d, expected none",
                             mode, {sec_inc, min_inc, hr_inc}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_mode", int'(mode), e.mode);
                    check("event_strobes", int'({sec_inc, min_inc, hr_inc}), e.strobes);
                end
            end
            prev_mode = mode;
        end
    end

    task automatic step(input logic mb, input logic ib, input logic rn, input int n);
        mode_btn = mb;
        inc_btn  = ib;
        reset_n  = rn;
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic press_mode();
        step(1'b1, 1'b0, 1'b1, 8);
        step(1'b0, 1'b0, 1'b1, 8);
    endtask

    initial begin
        // 1. Reset for three cycles, then free-running seconds ticks.
        step(1'b0, 1'b0, 1'b0, 3);
        check("reset_mode", int'(mode), 0);
        check("reset_carry_en", int'(carry_en), 1);
        check("reset_mode_led", int'(mode_led), 0);
        check("reset_strobes", int'({sec_inc, min_inc, hr_inc}), 0);
        step(1'b0, 1'b0, 1'b1, 35);

        // 2. Long mode hold: exactly one advance, no ticks in SET_SEC.
        step(1'b1, 1'b0, 1'b1, 12);
        step(1'b0, 1'b0, 1'b1, 50);
        check("hold_mode", int'(mode), 1);
        check("hold_carry_en", int'(carry_en), 0);
        check("hold_mode_led", int'(mode_led), 1);

        // 3. Short glitch and chatter are rejected.
        step(1'b1, 1'b0, 1'b1, 3);
        step(1'b0, 1'b0, 1'b1, 6);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 2);
            step(1'b0, 1'b0, 1'b1, 2);
        end
        check("glitch_mode", int'(mode), 1);

        // 4. SET_MIN increment.
        press_mode();
        check("set_min_mode", int'(mode), 2);
        step(1'b0, 1'b1, 1'b1, 8);
        step(1'b0, 1'b0, 1'b1, 8);
        check("after_min_inc_mode", int'(mode), 2);

        // 5. Wrap through RUN (inc ignored there), then simultaneous presses.
        press_mode();
        press_mode();
        check("run_mode", int'(mode), 0);
        step(1'b0, 1'b1, 1'b1, 8);
        step(1'b0, 1'b0, 1'b1, 8);
        press_mode();
        check("set_sec_mode", int'(mode), 1);
        step(1'b1, 1'b1, 1'b1, 8);
        step(1'b0, 1'b0, 1'b1, 8);
        check("simul_mode", int'(mode), 2);
        press_mode();
        press_mode();
        step(1'b0, 1'b0, 1'b1, 15);
        check("wrap_mode", int'(mode), 0);
        check("wrap_carry_en", int'(carry_en), 1);

        // 6. Reset while a press is mid-debounce in SET_HR.
        press_mode();
        press_mode();
        press_mode();
        check("set_hr_mode", int'(mode), 3);
        step(1'b1, 1'b0, 1'b1, 4);
        step(1'b0, 1'b0, 1'b0, 1);
        check("mid_reset_mode", int'(mode), 0);
        step(1'b0, 1'b0, 1'b1, 20);
        check("post_reset_mode", int'(mode), 0);

        // Random button activity with occasional resets.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                step(1'b0, 1'b0, 1'b0, 1);
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                     int'($urandom_range(1, 9)));
            end
        end
        step(1'b0, 1'b0, 1'b1, 20);
        @(negedge clock);
        #1;
        check("leftover_events", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
